jtopl_lfo_ctrl: RTL and testbench
=================================

// Module: jtopl_lfo_ctrl
// PURPOSE
//  LFO sequencer for the OPL operator pipeline. Generates the vibrato phase index and the
//  tremolo (AM) attenuation shared by all operators. Advances once per sample frame on
//  cenop&&zero and applies the global depth bits (reg 0xBD: DAM, DVB).
//  Sits beside the register bank; feeds the phase generator (vib_cnt) and the EG (am_val).
// PARAMETERS
//  AM_PRE   6        log2 of samples per tremolo step (64 samples/step)
//  AM_TOP   7'd105   tremolo triangle peak; full period = 2*AM_TOP steps
//  VIB_W    13       vibrato counter width; vib_cnt = cnt[VIB_W-1 -: 3]
// PORTS
//  clk      in   1  system clock
//  rst_n    in   1  asynchronous reset, active low
//  cenop    in   1  operator clock enable
//  zero     in   1  first slot of sample frame (qualified by cenop)
//  am_dep   in   1  DAM: 1 = 4.8 dB tremolo, 0 = 1 dB
//  vib_dep  in   1  DVB: 1 = 14 cent vibrato, 0 = 7 cent
//  lfo_rst  in   1  synchronous LFO clear (test register bit)
//  vib_cnt  out  3  vibrato phase index
//  vib_dep_o out 1  registered vib_dep, aligned with vib_cnt
//  am_val   out  5  tremolo attenuation, 0..26
// BEHAVIOUR
//  - One clock domain; async active-low reset. All outputs registered.
//  - Reset: vib counter=0, am prescaler=0, am_cnt=0, dir=UP, vib_cnt=0, vib_dep_o=0, am_val=0.
//  - tick = cenop & zero. Counters change only on tick; outputs visible the clock after.
//  - Vibrato: VIB_W-bit counter +1 per tick, free wrap (8191 -> 0); period 8192 samples.
//  - Tremolo prescaler: AM_PRE-bit counter +1 per tick; step = tick & (pre == all ones).
//  - Tremolo FSM (dir), on step:
//      UP:   am_cnt==AM_TOP -> dir<=DOWN, am_cnt<=AM_TOP-1; else am_cnt+1
//      DOWN: am_cnt==0      -> dir<=UP,   am_cnt<=1;        else am_cnt-1
//    Sequence 0,1..105,104..1,0,1..; each value held 64 samples; period 13440 samples.
//  - am_val updated on every cenop (not only tick) so depth changes land within one cenop:
//      am_dep=1: am_cnt[6:2] (0..26); am_dep=0: {2'b0, am_cnt[6:4]} (0..6).
//  - vib_dep_o <= vib_dep on every cenop.
//  - lfo_rst (sampled when cenop=1): clears vib counter, prescaler, am_cnt, dir=UP.
//    lfo_rst has priority over a simultaneous tick (no advance that cycle).
//    am_val reads 0 from the next cenop after clear.
//  - cenop=0: full hold, including with zero=1 or lfo_rst=1.
//  - rst_n low mid-operation: immediate return to reset values, independent of clk.
// CONFIGURATION
//  JTOPL_LFO_TEST_EN
//   defined:  extra input lfo_fast (1 bit, after lfo_rst). When 1, prescaler is bypassed
//             (step = tick) and vib counter adds 2^(VIB_W-3) per tick (vib_cnt +1/sample).
//             Prescaler held while lfo_fast=1; resumes from held value when it drops.
//   undefined: port absent; normal rates only.
// TESTING
//  1 Reset: rst_n=0 with ticks running -> all outputs 0, dir UP; release -> first tick gives
//    vib counter=1, am_val still 0.
//  2 Vibrato: 1024 ticks -> vib_cnt=1; 8192 ticks -> vib_cnt wraps to 0.
//  3 Tremolo triangle, am_dep=1: after 64*105 ticks am_cnt=105, am_val=26; +64 ticks 104;
//    after 64*210 ticks am_cnt=0, next step 1. am_dep=0 at peak -> am_val=6 next cenop.
//  4 lfo_rst coincident with tick at am_cnt=50, dir DOWN -> am_cnt=0, dir UP, vib=0,
//    no advance; next step -> am_cnt=1.
//  5 Gating: zero=1, cenop=0 for 100 clocks -> no counter change; tick only on cenop&zero.
//  6 JTOPL_LFO_TEST_EN: lfo_fast=1 -> am_cnt +1 per tick, vib_cnt +1 per tick, 8 ticks wrap.

Source files
------------

// File: rtl/jtopl_lfo_ctrl.sv
// LFO sequencer: vibrato phase index and tremolo attenuation shared by all operators.
// Optional JTOPL_LFO_TEST_EN adds the lfo_fast input for accelerated LFO rates.
module jtopl_lfo_ctrl #(
  parameter int         AM_PRE = 6,
  parameter logic [6:0] AM_TOP = 7'd105,
  parameter int         VIB_W  = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       zero,
  input  logic       am_dep,
  input  logic       vib_dep,
  input  logic       lfo_rst,
`ifdef JTOPL_LFO_TEST_EN
  input  logic       lfo_fast,
`endif
  output logic [2:0] vib_cnt,
  output logic       vib_dep_o,
  output logic [4:0] am_val
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  localparam logic [VIB_W-1:0]  VIB_ONE  = VIB_W'(1);
  localparam logic [VIB_W-1:0]  VIB_FAST = VIB_W'(1) << (VIB_W - 3);
  localparam logic [AM_PRE-1:0] PRE_ONE  = AM_PRE'(1);

  logic [VIB_W-1:0]  vib;
  logic [AM_PRE-1:0] pre;
  logic [6:0]        am_cnt, am_nx;
  dir_t              dir, dir_nx;
  logic              tick, step, fast;
  logic [VIB_W-1:0]  vib_inc;

  assign tick = cenop & zero;

`ifdef JTOPL_LFO_TEST_EN
  assign fast = lfo_fast;
`else
  assign fast = 1'b0;
`endif

  assign step    = tick & (fast | (&pre));
  assign vib_inc = fast ? VIB_FAST : VIB_ONE;
  assign vib_cnt = vib[VIB_W-1 -: 3];

  // Frame counters plus the output registers refreshed on every cenop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vib       <= '0;
      pre       <= '0;
      am_val    <= '0;
      vib_dep_o <= 1'b0;
    end else if (cenop) begin
      if (lfo_rst) begin
        vib <= '0;
        pre <= '0;
      end else if (zero) begin
        vib <= vib + vib_inc;
        if (!fast) pre <= pre + PRE_ONE;
      end
      am_val    <= am_dep ? am_cnt[6:2] : {2'b00, am_cnt[6:4]};
      vib_dep_o <= vib_dep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_cnt <= '0;
      dir    <= UP;
    end else begin
      am_cnt <= am_nx;
      dir    <= dir_nx;
    end
  end

  // Triangle walker; a clear wins over a coincident step.
  always_comb begin
    am_nx  = am_cnt;
    dir_nx = dir;
    if (cenop && lfo_rst) begin
      am_nx  = '0;
      dir_nx = UP;
    end else if (step) begin
      case (dir)
        UP: begin
          if (am_cnt == AM_TOP) begin
            dir_nx = DOWN;
            am_nx  = AM_TOP - 7'd1;
          end else begin
            am_nx  = am_cnt + 7'd1;
          end
        end
        DOWN: begin
          if (am_cnt == 7'd0) begin
            dir_nx = UP;
            am_nx  = 7'd1;
          end else begin
            am_nx  = am_cnt - 7'd1;
          end
        end
        default: begin
          dir_nx = UP;
          am_nx  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_lfo_ctrl.sv
// Bench for jtopl_lfo_ctrl: directed LFO sequence plus random gating, checked against
// a model that derives outputs from the tick count since the last clear.
module tb_jtopl_lfo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cenop, zero, am_dep, vib_dep, lfo_rst;
`ifdef JTOPL_LFO_TEST_EN
  logic       lfo_fast = 1'b0;
`endif
  logic [2:0] vib_cnt;
  logic       vib_dep_o;
  logic [4:0] am_val;

  int checks = 0;
  int errors = 0;

  // Model state: ticks since clear, plus the expected registered outputs.
  int   n_ticks = 0;
  int   am_val_exp = 0;
  logic vib_dep_exp = 1'b0;

  jtopl_lfo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cenop     (cenop),
    .zero      (zero),
    .am_dep    (am_dep),
    .vib_dep   (vib_dep),
    .lfo_rst   (lfo_rst),
`ifdef JTOPL_LFO_TEST_EN
    .lfo_fast  (lfo_fast),
`endif
    .vib_cnt   (vib_cnt),
    .vib_dep_o (vib_dep_o),
    .am_val    (am_val)
  );

  always #5 clk = ~clk;

  // Tremolo level as a triangle over 210 steps of 64 samples each.
  function automatic int am_level(input int n);
    int s;
    s = (n / 64) % 210;
    return (s <= 105) ? s : 210 - s;
  endfunction

  function automatic int vib_exp(input int n);
    return (n % 8192) / 1024;
  endfunction

  task automatic check_value(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic check_output(input string tag);
    check_value({tag, ".vib_cnt"}, int'(vib_cnt), vib_exp(n_ticks));
    check_value({tag, ".am_val"}, int'(am_val), am_val_exp);
    check_value({tag, ".vib_dep_o"}, int'(vib_dep_o), int'(vib_dep_exp));
  endtask

  // One clock with given inputs; model advanced at the edge, outputs checked 1 time unit later.
  task automatic apply_stimulus(input logic cen, input logic zr, input logic lrst,
                                input logic adep, input logic vdep, input string tag);
    cenop   = cen;
    zero    = zr;
    lfo_rst = lrst;
    am_dep  = adep;
    vib_dep = vdep;
    @(posedge clk);
    if (rst_n && cen) begin
      am_val_exp  = adep ? (am_level(n_ticks) >> 2) : (am_level(n_ticks) >> 4);
      vib_dep_exp = vdep;
      if (lrst) n_ticks = 0;
      else if (zr) n_ticks++;
    end
    #1;
    check_output(tag);
  endtask

  task automatic run_ticks(input int k, input string tag);
    for (int i = 0; i < k; i++)
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), tag);
  endtask

  initial begin
    rst_n = 1'b0;
    cenop = 1'b0; zero = 1'b0; am_dep = 1'b0; vib_dep = 1'b0; lfo_rst = 1'b0;

    // Reset held while ticks run
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "reset_hold");
    check_value("reset.am_val_const", int'(am_val), 0);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "first_tick");
    check_value("first_tick.am_val_const", int'(am_val), 0);

    // Vibrato step and wrap
    run_ticks(1023, "vib_run");
    check_value("vib_1024.const", int'(vib_cnt), 1);
    run_ticks(8192 - 1024, "vib_run2");
    check_value("vib_wrap.const", int'(vib_cnt), 0);

    // Tremolo triangle from a clean clear
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "clear1");
    run_ticks(64 * 105, "am_up");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "am_peak_dep1");
    check_value("am_peak_dep1.const", int'(am_val), 26);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "am_peak_dep0");
    check_value("am_peak_dep0.const", int'(am_val), 6);
    run_ticks(64, "am_104");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "am_104_chk");
    check_value("am_104.const", int'(am_val), 26);
    run_ticks(64 * 104, "am_down");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "am_zero_chk");
    check_value("am_zero.const", int'(am_val), 0);
    run_ticks(64 * 4, "am_restart");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "am_restart_chk");
    check_value("am_restart4.const", int'(am_val), 1);

    // Clear coincident with a tick while descending at level 50
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "clear2");
    run_ticks(64 * 160, "am_to_50");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "am_50_chk");
    check_value("am_50.const", int'(am_val), 12);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "clear_tick");
    check_value("clear_tick.vib.const", int'(vib_cnt), 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "after_clear");
    check_value("after_clear.am_val.const", int'(am_val), 0);
    run_ticks(64 * 4, "post_clear");

    // Gating: nothing moves while cenop is low
    for (int i = 0; i < 100; i++)
      apply_stimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), "gated");

    // Random mix of enables, frame starts, clears and depth changes
    for (int i = 0; i < 6000; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 255) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), "random");

    // Asynchronous reset mid-run, between clock edges
    run_ticks(3000, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    n_ticks = 0; am_val_exp = 0; vib_dep_exp = 1'b0;
    check_output("async_reset");
    #1;
    rst_n = 1'b1;
    run_ticks(1100, "post_async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
